// File: rtl/ppa_sum_stage.sv
`default_nettype none
// ============================================================================
// Module      : ppa_sum_stage
// Description : Final sum stage of a parallel-prefix adder. It forms the carries
//               from the prefix-tree group generate/propagate and the carry-in,
//               then computes sum, carry-out and signed overflow. Results pass
//               through a 2-entry ready/valid output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module ppa_sum_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] p_in,
    input  logic [WIDTH-1:0] gg_in,
    input  logic [WIDTH-1:0] gp_in,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [15:0]      op_count
);

    // Each entry is packed as {cout, ovf, sum}.
    localparam int ENTRY_W = WIDTH + 2;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [ENTRY_W-1:0]   r_head;
    logic [ENTRY_W-1:0]   r_tail;
    logic [15:0]          r_op_count;
    logic [WIDTH:0]       w_carry;
    logic [ENTRY_W-1:0]   w_result;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_load_head;
    logic                 w_load_tail;
    logic                 w_promote;

    // Carry into bit i is the group generate of bits below it, plus cin when
    // the whole lower group propagates.
    assign w_carry[0] = cin;
    for (genvar i = 1; i <= WIDTH; i++) begin : g_carry
        assign w_carry[i] = gg_in[i-1] | (gp_in[i-1] & cin);
    end

    assign w_result = {w_carry[WIDTH],
                       w_carry[WIDTH] ^ w_carry[WIDTH-1],
                       p_in ^ w_carry[WIDTH-1:0]};

    // Handshake flags are decoded from the registered state only; gating with
    // rst keeps both sides quiet while reset is held.
    assign in_ready   = (r_state != S_FULL)  && !rst;
    assign out_valid  = (r_state != S_EMPTY) && !rst;
    assign w_in_fire  = in_valid  && in_ready;
    assign w_out_fire = out_valid && out_ready;

    assign sum      = rst ? '0 : r_head[WIDTH-1:0];
    assign ovf      = rst ? 1'b0 : r_head[WIDTH];
    assign cout     = rst ? 1'b0 : r_head[WIDTH+1];
    assign op_count = rst ? 16'd0 : r_op_count;

    // Next-state and buffer-update decode for the EMPTY/ONE/FULL buffer.
    always_comb begin
        w_state_next = r_state;
        w_load_head  = 1'b0;
        w_load_tail  = 1'b0;
        w_promote    = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_in_fire) begin
                    w_state_next = S_ONE;
                    w_load_head  = 1'b1;
                end
            end
            S_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    // Head leaves and the new result takes its place.
                    w_load_head  = 1'b1;
                end else if (w_in_fire) begin
                    w_state_next = S_FULL;
                    w_load_tail  = 1'b1;
                end else if (w_out_fire) begin
                    w_state_next = S_EMPTY;
                end
            end
            S_FULL: begin
                // in_ready is low here, so no input can be accepted.
                if (w_out_fire) begin
                    w_state_next = S_ONE;
                    w_promote    = 1'b1;
                end
            end
            default: begin
                w_state_next = S_EMPTY;
            end
        endcase
    end

    // State, buffer entries and output transfer counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_EMPTY;
            r_head     <= '0;
            r_tail     <= '0;
            r_op_count <= 16'd0;
        end else begin
            r_state <= w_state_next;
            if (w_load_head) begin
                r_head <= w_result;
            end else if (w_promote) begin
                r_head <= r_tail;
            end
            if (w_load_tail) begin
                r_tail <= w_result;
            end
            if (w_out_fire) begin
                r_op_count <= r_op_count + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ppa_sum_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ppa_sum_stage
// Description : Directed self-checking bench for ppa_sum_stage at WIDTH=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ppa_sum_stage;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] p_in;
    logic [WIDTH-1:0] gg_in;
    logic [WIDTH-1:0] gp_in;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [15:0]      op_count;

    int n_total;
    int n_pass;

    ppa_sum_stage #(.WIDTH(WIDTH)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p_in      (p_in),
        .gg_in     (gg_in),
        .gp_in     (gp_in),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .op_count  (op_count)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] p, input logic [7:0] gg,
                         input logic [7:0] gp, input logic c);
        p_in     = p;
        gg_in    = gg;
        gp_in    = gp;
        cin      = c;
        in_valid = 1'b1;
    endtask

    // Checks the head result as {cout, ovf, sum}.
    task automatic check_head(input string tag, input logic [9:0] exp);
        check(tag, 64'({cout, ovf, sum}), 64'(exp));
    endtask

    initial begin
        n_total   = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        p_in      = '0;
        gg_in     = '0;
        gp_in     = '0;
        cin       = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check_head("rst_result", 10'h000);
        check("rst_op_count",  64'(op_count),  64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // 0x7E + 0x7F style vector: signed overflow into 0x80.
        out_ready = 1'b1;
        drive(8'h7E, 8'h7F, 8'h00, 1'b0);
        tick();
        in_valid = 1'b0;
        check("v1_out_valid", 64'(out_valid), 64'd1);
        check_head("v1_result", {1'b0, 1'b1, 8'h80});
        check("v1_count_before", 64'(op_count), 64'd0);
        tick();
        check("v1_op_count", 64'(op_count), 64'd1);
        check("v1_drained", 64'(out_valid), 64'd0);

        // Unsigned carry-out with no overflow, then back-to-back with cin.
        drive(8'hFE, 8'hFF, 8'h00, 1'b0);
        tick();
        check_head("v2_result", {1'b1, 1'b0, 8'h00});
        drive(8'hFF, 8'h00, 8'hFF, 1'b1);
        tick();
        in_valid = 1'b0;
        check_head("v3_result", {1'b1, 1'b0, 8'h00});
        check("v3_out_valid", 64'(out_valid), 64'd1);
        check("v3_op_count", 64'(op_count), 64'd2);
        tick();
        check("v3_op_count_after", 64'(op_count), 64'd3);

        // Stall: three back-to-back inputs with out_ready low.
        // A: p=0x01,gg=0x00,gp=0x01,cin=1 -> c=0x03 low, sum=0x02, cout=0, ovf=0
        // B: p=0x80,gg=0x00,gp=0x00,cin=0 -> sum=0x80, cout=0, ovf=0
        // C: p=0x00,gg=0x80,gp=0x00,cin=0 -> c8=1, c7=0: sum=0x00, cout=1, ovf=1
        out_ready = 1'b0;
        drive(8'h01, 8'h00, 8'h01, 1'b1);
        tick();
        check("stall_a_in_ready", 64'(in_ready), 64'd1);
        drive(8'h80, 8'h00, 8'h00, 1'b0);
        tick();
        check("stall_full_in_ready", 64'(in_ready), 64'd0);
        drive(8'h00, 8'h80, 8'h00, 1'b0);
        tick();
        check("stall_hold_in_ready", 64'(in_ready), 64'd0);
        check_head("stall_hold_a", {1'b0, 1'b0, 8'h02});
        tick();
        check_head("stall_hold_a2", {1'b0, 1'b0, 8'h02});
        check("stall_count", 64'(op_count), 64'd3);
        out_ready = 1'b1;
        tick();
        check_head("stall_b_head", {1'b0, 1'b0, 8'h80});
        check("stall_b_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check_head("stall_c_head", {1'b1, 1'b1, 8'h00});
        check("stall_c_valid", 64'(out_valid), 64'd1);
        tick();
        check("stall_drained", 64'(out_valid), 64'd0);
        check("stall_op_count", 64'(op_count), 64'd6);

        // Reset while FULL.
        out_ready = 1'b0;
        drive(8'h0F, 8'h00, 8'h00, 1'b0);
        tick();
        drive(8'hF0, 8'h00, 8'h00, 1'b0);
        tick();
        in_valid = 1'b0;
        check("full_before_rst", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        check("rstfull_out_valid", 64'(out_valid), 64'd0);
        check("rstfull_op_count", 64'(op_count), 64'd0);
        rst = 1'b0;
        tick();
        check("rstfull_no_stale", 64'(out_valid), 64'd0);
        check("rstfull_in_ready", 64'(in_ready), 64'd1);
        check("rstfull_count_hold", 64'(op_count), 64'd0);
        // Fresh vector after reset: p=0x33,gg=0x0C,gp=0x03,cin=1
        // c[1]=gg0|gp0 =1, c[2]=1, c[3]=gg2=1, c[4]=gg3=1, others 0 -> c=0x1F
        // sum=0x33^0x1F=0x2C, cout=0, ovf=0
        drive(8'h33, 8'h0C, 8'h03, 1'b1);
        tick();
        in_valid = 1'b0;
        check_head("post_rst_vec", {1'b0, 1'b0, 8'h2C});
        tick();
        check("post_rst_count", 64'(op_count), 64'd1);

        // op_count wrap: reset, then stream one transfer per cycle.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        drive(8'h00, 8'h00, 8'h00, 1'b0);
        tick();
        check("wrap_start", 64'(op_count), 64'd0);
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        check("wrap_ffff", 64'(op_count), 64'hFFFF);
        tick();
        check("wrap_zero", 64'(op_count), 64'd0);
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
